mips_mem_arb: RTL and testbench

Single-port memory arbiter for the `mips` core. It shares one unified instruction/data memory port between the fetch stage (IF) and the memory stage (DM). DM has priority, and a starvation guard bounds how long fetch can wait. The block also produces per-requester stall signals used by the pipeline control.

---
 rtl/mips_mem_arb.sv | 93 +++++++++
 tb/tb_mips_mem_arb.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_arb.sv
// mips_mem_arb: single-port memory arbiter between fetch (IF) and data (DM) with DM priority and a starvation guard
module mips_mem_arb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_done,
  output logic                if_stall,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_done,
  output logic                dm_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;
  state_t state;
  logic [3:0] starve_cnt;
  logic if_el, dm_el, grant_if, grant_dm, starved;
  // a request raised in the same cycle as its own done is not a new request
  assign if_el    = if_req & ~if_done;
  assign dm_el    = dm_req & ~dm_done;
  assign starved  = starve_cnt == 4'(STARVE_MAX);
  assign grant_if = if_el & (~dm_el | starved);
  assign grant_dm = dm_el & ~grant_if;
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      busy       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      if (state == IDLE) begin
        if (grant_if) begin
          state      <= BUSY_IF;
          busy       <= 1'b1;
          mem_req    <= 1'b1;
          mem_we     <= 1'b0;
          mem_addr   <= if_addr;
          mem_be     <= '1;
          starve_cnt <= '0;
        end else if (grant_dm) begin
          state      <= BUSY_DM;
          busy       <= 1'b1;
          mem_req    <= 1'b1;
          mem_we     <= dm_we;
          mem_addr   <= dm_addr;
          mem_wdata  <= dm_wdata;
          mem_be     <= dm_be;
          starve_cnt <= (if_el && !starved) ? starve_cnt + 4'd1 : starve_cnt;
        end
      end else if (mem_ack) begin
        state   <= IDLE;
        busy    <= 1'b0;
        mem_req <= 1'b0;
        if (state == BUSY_IF) begin
          if_rdata <= mem_rdata;
          if_done  <= 1'b1;
        end else begin
          dm_rdata <= mem_we ? dm_rdata : mem_rdata;
          dm_done  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mips_mem_arb.sv
// tb_mips_mem_arb: directed and randomized checks of mips_mem_arb against a transaction-level reference model
module tb_mips_mem_arb;
  localparam int SM = 2;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_req = 0, dm_req = 0, dm_we = 0, mem_ack = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic [3:0]  dm_be = 0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        if_done, if_stall, dm_done, dm_stall, mem_req, mem_we, busy;

  mips_mem_arb #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int m_who, m_cnt, n_if_grant, n_dm_grant;
  bit m_if_done, m_dm_done, m_we;
  logic [31:0] m_if_rdata, m_dm_rdata, m_addr, m_wdata;
  logic [3:0]  m_be;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_who = 0; m_cnt = 0; m_if_done = 0; m_dm_done = 0; m_we = 0;
    m_if_rdata = 0; m_dm_rdata = 0; m_addr = 0; m_wdata = 0; m_be = 0;
  endtask

  task automatic check_reset();
    check("rst_busy", 64'(busy), 0);
    check("rst_mem_req", 64'(mem_req), 0);
    check("rst_mem_we", 64'(mem_we), 0);
    check("rst_mem_addr", 64'(mem_addr), 0);
    check("rst_mem_wdata", 64'(mem_wdata), 0);
    check("rst_mem_be", 64'(mem_be), 0);
    check("rst_if_done", 64'(if_done), 0);
    check("rst_dm_done", 64'(dm_done), 0);
    check("rst_if_rdata", 64'(if_rdata), 0);
    check("rst_dm_rdata", 64'(dm_rdata), 0);
  endtask

  // advance one clock; the model consumes the inputs that were present at the edge
  task automatic step();
    bit ie, de, ifd, dmd;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
      check_reset();
      return;
    end
    ifd = 0; dmd = 0;
    if (m_who != 0) begin
      if (mem_ack) begin
        if (m_who == 1) begin ifd = 1; m_if_rdata = mem_rdata; end
        else begin dmd = 1; if (!m_we) m_dm_rdata = mem_rdata; end
        m_who = 0;
      end
    end else begin
      ie = if_req && !m_if_done;
      de = dm_req && !m_dm_done;
      if (ie && (!de || m_cnt == SM)) begin
        m_who = 1; m_cnt = 0; m_we = 0; m_addr = if_addr; m_be = 4'hF; n_if_grant++;
      end else if (de) begin
        m_who = 2; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata; m_be = dm_be; n_dm_grant++;
        if (ie) m_cnt = (m_cnt < SM) ? m_cnt + 1 : SM;
      end
    end
    m_if_done = ifd;
    m_dm_done = dmd;
    check("busy", 64'(busy), 64'(m_who != 0));
    check("mem_req", 64'(mem_req), 64'(m_who != 0));
    check("if_done", 64'(if_done), 64'(m_if_done));
    check("dm_done", 64'(dm_done), 64'(m_dm_done));
    check("if_rdata", 64'(if_rdata), 64'(m_if_rdata));
    check("dm_rdata", 64'(dm_rdata), 64'(m_dm_rdata));
    check("if_stall", 64'(if_stall), 64'(if_req && !m_if_done));
    check("dm_stall", 64'(dm_stall), 64'(dm_req && !m_dm_done));
    if (m_who != 0) begin
      check("mem_addr", 64'(mem_addr), 64'(m_addr));
      check("mem_we", 64'(mem_we), 64'(m_we));
      check("mem_be", 64'(mem_be), 64'(m_be));
    end
    if (m_who == 2) check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
  endtask

  task automatic drive_rand();
    mem_ack   = (m_who != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
    mem_rdata = $urandom;
    if (!if_req || m_if_done) begin
      if_req  = $urandom_range(0, 3) != 0;
      if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!dm_req || m_dm_done) begin
      dm_req   = $urandom_range(0, 4) != 0;
      dm_we    = 1'($urandom);
      dm_addr  = $urandom & 32'hFFFF_FFFC;
      dm_wdata = $urandom;
      dm_be    = 4'($urandom);
    end
  endtask

  initial begin
    model_reset();
    n_if_grant = 0; n_dm_grant = 0;
    #2 check_reset();
    step();
    rst = 0;
    // spurious acks while idle
    mem_ack = 1;
    repeat (3) step();
    mem_ack = 0;
    check("spur_busy", 64'(busy), 0);
    // IF-only fetch, ack two cycles after mem_req
    if_req = 1; if_addr = 32'h40;
    step();
    check("t1_we", 64'(mem_we), 0);
    check("t1_be", 64'(mem_be), 64'hF);
    step();
    mem_ack = 1; mem_rdata = 32'h2008_0005;
    step();
    mem_ack = 0;
    check("t1_done", 64'(if_done), 1);
    check("t1_rdata", 64'(if_rdata), 64'h2008_0005);
    if_req = 0;
    step();
    // DM write with zero-latency ack
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'h3;
    step();
    check("t2_addr", 64'(mem_addr), 64'h100);
    check("t2_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    check("t2_be", 64'(mem_be), 64'h3);
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 0;
    check("t2_done", 64'(dm_done), 1);
    check("t2_rdata", 64'(dm_rdata), 0);
    dm_req = 0;
    step();
    // simultaneous requests: DM first, IF in the DM done cycle
    if_req = 1; if_addr = 32'h80; dm_req = 1; dm_we = 0; dm_addr = 32'h200;
    step();
    check("t3_first", 64'(mem_addr), 64'h200);
    mem_ack = 1; mem_rdata = 32'hAAAA_0001;
    step();
    mem_ack = 0; dm_req = 0;
    step();
    check("t3_second", 64'(mem_addr), 64'h80);
    mem_ack = 1; mem_rdata = 32'hBBBB_0002;
    step();
    mem_ack = 0;
    check("t3_if_done", 64'(if_done), 1);
    if_req = 0;
    step();
    // contention with DM re-requesting after every done
    if_req = 1; if_addr = 32'hC0; dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    for (int g = 0; g < 4; g++) begin
      step();
      mem_ack = 1; mem_rdata = $urandom;
      step();
      mem_ack = 0;
      if (if_done) if_req = 0;
    end
    if_req = 0; dm_req = 0;
    repeat (3) step();
    // reset in the middle of a DM access, then a late ack
    dm_req = 1; dm_we = 0; dm_addr = 32'h400;
    step();
    check("t5_busy", 64'(busy), 1);
    rst = 1; dm_req = 0;
    #1 check_reset();
    step();
    #2 rst = 0;
    mem_ack = 1;
    step();
    mem_ack = 0;
    check("t5_no_done", 64'(dm_done), 0);
    check("t5_idle", 64'(busy), 0);
    step();
    // randomized traffic
    repeat (4000) begin
      drive_rand();
      step();
    end
    check("rand_if_grants", 64'(n_if_grant > 20), 1);
    check("rand_dm_grants", 64'(n_dm_grant > 20), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
